// File: rtl/dmem_responder_if.sv
// Data-memory request/response bundle between a core (master) and the responder (slave).
// Signals keep the core's dmem_* names so traces line up with the core's own ports.
interface dmem_responder_if;
    logic        dmem_req;
    logic        dmem_wr_en;
    logic [1:0]  dmem_size;
    logic        dmem_zero_extend;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wr_data;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rd_data;
    logic        dmem_err;

    modport master (
        output dmem_req, dmem_wr_en, dmem_size, dmem_zero_extend, dmem_addr, dmem_wr_data,
        input  dmem_gnt, dmem_rvalid, dmem_rd_data, dmem_err
    );

    modport slave (
        input  dmem_req, dmem_wr_en, dmem_size, dmem_zero_extend, dmem_addr, dmem_wr_data,
        output dmem_gnt, dmem_rvalid, dmem_rd_data, dmem_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Single-port data memory answering one core request at a time; DMEM_MISALIGN_CHECK_EN flags misaligned half/word.
// Latency: response strobe WAIT_STATES+1 cycles after the accept edge.
// Backpressure: dmem_gnt only in IDLE; the core holds dmem_req until granted.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  dmem
);
    localparam int         AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic          gnt_q, rvalid_q, err_q;
    logic [31:0]   rd_data_q;

    logic          wr_q, ze_q;
    logic [1:0]    size_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          accept, fire;
    logic          op_wr, op_ze, op_err;
    logic [1:0]    op_size, lane;
    logic [AW+1:0] op_addr;
    logic [31:0]   op_wdata, wdata_lanes, rd_word, load_val;
    logic [AW-1:0] idx;
    logic [3:0]    be;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;

    logic unused_addr_hi;
    assign unused_addr_hi = &{1'b0, dmem.dmem_addr[31:AW+2]};

    assign accept = dmem.dmem_req && gnt_q;
    assign fire   = (accept && WS == 4'd0) || (state == WAIT && cnt == 4'd1);

    // With zero wait states the access completes on the accept edge itself, so use the live inputs.
    always_comb begin
        if (state == IDLE) begin
            op_wr    = dmem.dmem_wr_en;
            op_ze    = dmem.dmem_zero_extend;
            op_size  = dmem.dmem_size;
            op_addr  = dmem.dmem_addr[AW+1:0];
            op_wdata = dmem.dmem_wr_data;
        end else begin
            op_wr    = wr_q;
            op_ze    = ze_q;
            op_size  = size_q;
            op_addr  = addr_q;
            op_wdata = wdata_q;
        end
    end

    assign idx  = op_addr[AW+1:2];
    assign lane = op_addr[1:0];

    always_comb begin
        op_err = (op_size == 2'b11);
`ifdef DMEM_MISALIGN_CHECK_EN
        if (op_size == 2'b01 && lane[0])
            op_err = 1'b1;
        if (op_size == 2'b10 && lane != 2'b00)
            op_err = 1'b1;
`endif
    end

    always_comb begin
        be          = 4'b0000;
        wdata_lanes = op_wdata;
        case (op_size)
            2'b00: begin
                be          = 4'b0001 << lane;
                wdata_lanes = {4{op_wdata[7:0]}};
            end
            2'b01: begin
                be          = lane[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{op_wdata[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        if (op_err || !op_wr)
            be = 4'b0000;
    end

    assign rd_word  = mem[idx];
    assign byte_sel = rd_word[{lane, 3'b000} +: 8];
    assign half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        case (op_size)
            2'b00:   load_val = {{24{~op_ze & byte_sel[7]}}, byte_sel};
            2'b01:   load_val = {{16{~op_ze & half_sel[15]}}, half_sel};
            2'b10:   load_val = rd_word;
            default: load_val = 32'd0;
        endcase
    end

    // Storage is deliberately left out of reset; a reset on the commit edge cancels the write.
    always_ff @(posedge clk) begin
        if (!reset && fire) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i])
                    mem[idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            gnt_q     <= 1'b0;
            rvalid_q  <= 1'b0;
            rd_data_q <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            rvalid_q  <= 1'b0;
            rd_data_q <= 32'd0;
            err_q     <= 1'b0;
            if (fire) begin
                rvalid_q  <= 1'b1;
                err_q     <= op_err;
                rd_data_q <= (!op_wr && !op_err) ? load_val : 32'd0;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        wr_q    <= dmem.dmem_wr_en;
                        ze_q    <= dmem.dmem_zero_extend;
                        size_q  <= dmem.dmem_size;
                        addr_q  <= dmem.dmem_addr[AW+1:0];
                        wdata_q <= dmem.dmem_wr_data;
                        cnt     <= WS;
                        gnt_q   <= 1'b0;
                        state   <= (WS == 4'd0) ? RESP : WAIT;
                    end else begin
                        gnt_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd1)
                        state <= RESP;
                    else
                        cnt <= cnt - 4'd1;
                end
                RESP: begin
                    state <= IDLE;
                    gnt_q <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dmem.dmem_gnt     = gnt_q;
    assign dmem.dmem_rvalid  = rvalid_q;
    assign dmem.dmem_rd_data = rd_data_q;
    assign dmem.dmem_err     = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a byte-array memory model; covers a 2-wait-state
// instance (1024 words) and a zero-wait-state instance (16 words, exercises address wrap).
module tb_dmem_responder;
    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic        ze;
        logic [31:0] addr;
        logic [31:0] wd;
    } op_t;

    localparam int WS0 = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dmem_responder_if if0 ();
    dmem_responder_if if1 ();

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(WS0)) dut0 (.clk(clk), .reset(reset), .dmem(if0));
    dmem_responder #(.DEPTH_WORDS(16),   .WAIT_STATES(0))   dut1 (.clk(clk), .reset(reset), .dmem(if1));

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] mem0 [4096];
    logic [7:0] mem1 [64];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory seen as little-endian bytes; returns {err, rd_data}.
    function automatic logic [32:0] model_op(input int which, input op_t op);
        int nb, n, a, base;
        logic [31:0] val;
        nb = (which == 0) ? 4096 : 64;
        if (op.size == 2'b11)
            return {1'b1, 32'd0};
        n = 1 << op.size;
`ifdef DMEM_MISALIGN_CHECK_EN
        if ((op.addr % 32'(n)) != 0)
            return {1'b1, 32'd0};
`endif
        a    = int'(op.addr % 32'(nb));
        base = a - (a % n);
        val  = 32'd0;
        for (int i = 0; i < n; i++) begin
            if (op.wr) begin
                if (which == 0) mem0[base+i] = op.wd[8*i +: 8];
                else            mem1[base+i] = op.wd[8*i +: 8];
            end else begin
                val = val | (32'((which == 0) ? mem0[base+i] : mem1[base+i]) << (8*i));
            end
        end
        if (op.wr)
            return {1'b0, 32'd0};
        if (!op.ze && n < 4 && val[8*n-1])
            val = val | ~((32'd1 << (8*n)) - 32'd1);
        return {1'b0, val};
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.wr   = $urandom_range(0, 1) == 1;
        o.size = 2'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2));
        o.ze   = $urandom_range(0, 1) == 1;
        o.addr = $urandom;
        o.wd   = $urandom;
        return o;
    endfunction

    task automatic drive0(input op_t o);
        if0.dmem_wr_en       = o.wr;
        if0.dmem_size        = o.size;
        if0.dmem_zero_extend = o.ze;
        if0.dmem_addr        = o.addr;
        if0.dmem_wr_data     = o.wd;
    endtask

    task automatic drive1(input op_t o);
        if1.dmem_wr_en       = o.wr;
        if1.dmem_size        = o.size;
        if1.dmem_zero_extend = o.ze;
        if1.dmem_addr        = o.addr;
        if1.dmem_wr_data     = o.wd;
    endtask

    // One full transaction on the 2-wait-state instance, checked for latency, single strobe and data.
    task automatic txn0(input op_t o, output logic [31:0] rd, output logic er);
        logic [32:0] exp;
        int waitc, lat, nrv;
        rd = 32'd0; er = 1'b0; lat = 0; nrv = 0;
        @(negedge clk);
        drive0(o);
        if0.dmem_req = 1'b1;
        waitc = 0;
        while (!if0.dmem_gnt && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        check("gnt", {31'd0, if0.dmem_gnt}, 32'd1);
        exp = model_op(0, o);
        for (int c = 1; c <= WS0 + 3; c++) begin
            @(negedge clk);
            if0.dmem_req = 1'b0;
            if (if0.dmem_rvalid) begin
                nrv++;
                if (nrv == 1) begin
                    lat = c;
                    rd  = if0.dmem_rd_data;
                    er  = if0.dmem_err;
                end
            end else begin
                check("idle_out", if0.dmem_rd_data | {31'd0, if0.dmem_err}, 32'd0);
            end
        end
        check("rvalid_cnt", 32'(nrv), 32'd1);
        check("latency", 32'(lat), 32'(WS0 + 1));
        check("rd_data", rd, exp[31:0]);
        check("err", {31'd0, er}, {31'd0, exp[32]});
    endtask

    initial begin
        op_t o, cur;
        logic [31:0] rd;
        logic er;
        logic [32:0] e;
        logic [32:0] exp_q [$];
        int accepts, rvs;
        logic prev_gnt;
        localparam int NSTREAM = 60;

        if0.dmem_req = 1'b0; if1.dmem_req = 1'b0;
        drive0('0); drive1('0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_gnt0",    {31'd0, if0.dmem_gnt},    32'd0);
        check("rst_rvalid0", {31'd0, if0.dmem_rvalid}, 32'd0);
        check("rst_rd0",     if0.dmem_rd_data,         32'd0);
        check("rst_err0",    {31'd0, if0.dmem_err},    32'd0);
        check("rst_gnt1",    {31'd0, if1.dmem_gnt},    32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_gnt", {31'd0, if0.dmem_gnt}, 32'd1);

        // Fill every word so later loads compare against known contents.
        for (int w = 0; w < 1024; w++) begin
            o = '{wr: 1'b1, size: 2'b10, ze: 1'b0, addr: {$urandom_range(0, 1048575), 12'(w * 4)}, wd: $urandom};
            txn0(o, rd, er);
        end

        txn0('{1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF}, rd, er);
        check("st_word_rd", rd, 32'd0);
        txn0('{1'b0, 2'b00, 1'b0, 32'h13, 32'h0}, rd, er);
        check("ld_byte_sx", rd, 32'hFFFFFFDE);
        txn0('{1'b0, 2'b00, 1'b1, 32'h13, 32'h0}, rd, er);
        check("ld_byte_zx", rd, 32'h000000DE);
        txn0('{1'b1, 2'b01, 1'b0, 32'h12, 32'h1234}, rd, er);
        txn0('{1'b0, 2'b10, 1'b0, 32'h10, 32'h0}, rd, er);
        check("ld_word_mix", rd, 32'h1234BEEF);
        txn0('{1'b0, 2'b10, 1'b0, 32'h11, 32'h0}, rd, er);
`ifdef DMEM_MISALIGN_CHECK_EN
        check("misalign_rd",  rd, 32'd0);
        check("misalign_err", {31'd0, er}, 32'd1);
`else
        check("misalign_rd",  rd, 32'h1234BEEF);
        check("misalign_err", {31'd0, er}, 32'd0);
`endif
        txn0('{1'b0, 2'b11, 1'b0, 32'h10, 32'h0}, rd, er);
        check("size11_err", {31'd0, er}, 32'd1);

        // Store aborted by a reset pulse during its wait cycles.
        @(negedge clk);
        drive0('{1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D});
        if0.dmem_req = 1'b1;
        check("abort_gnt", {31'd0, if0.dmem_gnt}, 32'd1);
        @(negedge clk);
        if0.dmem_req = 1'b0;
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("abort_rst_gnt",    {31'd0, if0.dmem_gnt},    32'd0);
            check("abort_rst_rvalid", {31'd0, if0.dmem_rvalid}, 32'd0);
        end
        reset = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) check("abort_gnt_after", {31'd0, if0.dmem_gnt}, 32'd1);
            check("abort_no_rvalid", {31'd0, if0.dmem_rvalid}, 32'd0);
        end
        txn0('{1'b0, 2'b10, 1'b0, 32'h20, 32'h0}, rd, er);

        for (int k = 0; k < 200; k++) begin
            o = rand_op();
            txn0(o, rd, er);
        end

        // Zero-wait instance with the request held high throughout.
        accepts = 0; rvs = 0; prev_gnt = 1'b0;
        cur = '{1'b1, 2'b10, 1'b0, {$urandom_range(0, 67108863), 6'd0}, $urandom};
        @(negedge clk);
        drive1(cur);
        if1.dmem_req = 1'b1;
        for (int cyc = 0; cyc < 400 && accepts < NSTREAM; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (if1.dmem_rvalid) begin
                check("s_pending", 32'(exp_q.size()), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("s_rd",  if1.dmem_rd_data, e[31:0]);
                    check("s_err", {31'd0, if1.dmem_err}, {31'd0, e[32]});
                end
                rvs++;
            end else begin
                check("s_idle_out", if1.dmem_rd_data | {31'd0, if1.dmem_err}, 32'd0);
            end
            if (cyc == 0) check("s_gnt_first", {31'd0, if1.dmem_gnt}, 32'd1);
            else          check("s_gnt_alt",   {31'd0, if1.dmem_gnt}, {31'd0, ~prev_gnt});
            prev_gnt = if1.dmem_gnt;
            if (if1.dmem_gnt) begin
                exp_q.push_back(model_op(1, cur));
                accepts++;
                @(posedge clk);
                #1;
                if (accepts < 16)
                    cur = '{1'b1, 2'b10, 1'b0, {$urandom_range(0, 67108863), 4'(accepts), 2'b00}, $urandom};
                else
                    cur = rand_op();
                drive1(cur);
            end
        end
        if1.dmem_req = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (if1.dmem_rvalid) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("s_rd",  if1.dmem_rd_data, e[31:0]);
                    check("s_err", {31'd0, if1.dmem_err}, {31'd0, e[32]});
                end
                rvs++;
            end
        end
        check("s_accepts", 32'(accepts), 32'(NSTREAM));
        check("s_rvalids", 32'(rvs), 32'(accepts));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
